risc5_muldiv_unit: RTL and testbench
====================================

Name: risc5_muldiv_unit

Overview:
- Parametrised iterative RV32M/RV64M multiply/divide unit for the 5-stage Risc5 pipeline.
- Sits beside the EX-stage ALU. The EX stage launches an M-extension op with `start`.
- The unit raises `busy`, which ORs into the pipeline Stall, until `done` returns the result.
- `flush` from the branch/jump logic aborts an in-flight op.

Parameters:
- XLEN, 32, operand/result width; must be ≥8 and even.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- start  input  1  launch request; sampled only in IDLE
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  XLEN  rs1 operand; captured on accepted start
- op_b  input  XLEN  rs2 operand; captured on accepted start
- flush  input  1  abort current op (pipeline flush)
- busy  output  1  op in progress; drives Stall
- done  output  1  one-cycle pulse; `result` valid this cycle
- result  output  XLEN  op result; holds its value until the next done

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to IDLE.
  - busy=0, done=0, result=0, counter=0.
  - Internal operand/accumulator registers are cleared.
  - Reset overrides all other inputs, including mid-operation; no done is produced for the aborted op.
- States: IDLE, CALC, FIN.
  - IDLE: start=1 and flush=0 at edge k → capture op_a, op_b, funct3.
    - Signed ops: record operand signs and convert operands to magnitudes.
    - counter=XLEN.
    - Special division cases (see below) go to FIN; all other ops go to CALC.
    - busy=1 from cycle k+1.
  - CALC: one radix-2 step per cycle; counter decrements by 1.
    - Multiply: shift-add over a 2*XLEN product.
    - Divide: restoring shift-subtract producing quotient and remainder.
    - When counter reaches 1 in CALC, the next state is FIN.
  - FIN: apply sign correction and select the output word.
    - MUL: low XLEN bits of the product.
    - MULH, MULHSU, MULHU: high XLEN bits of the product.
    - DIV, DIVU: quotient. REM, REMU: remainder.
    - Register `result`, assert done=1 and busy=0 for exactly one cycle, then go to IDLE.
- Latency (normal path): start at edge k → busy=1 in cycles k+1..k+XLEN+1 → done=1 in cycle k+XLEN+2 (34 cycles for XLEN=32).
- Sign rules:
  - MULHSU: op_a is signed, op_b is unsigned.
  - DIV/REM: the quotient is negated if the operand signs differ; the remainder takes the sign of the dividend.
- Divide by zero (op_b==0), bypassing CALC:
  - DIV/DIVU quotient = all ones.
  - REM/REMU remainder = op_a.
  - done appears in cycle k+2.
- Signed overflow (DIV/REM with op_a = -2^(XLEN-1) and op_b = -1), bypassing CALC:
  - quotient = op_a, remainder = 0.
  - done appears in cycle k+2.
- start while busy: ignored; the in-flight op is not disturbed.
- start in the done cycle: ignored. The next start is accepted from the cycle after done.
- flush=1 in CALC or FIN: go to IDLE at the next edge. busy=0, no done; result keeps its old value.
- flush=1 with start=1 in IDLE: start is ignored.
- funct3 is decoded only at capture; changes on funct3, op_a and op_b while busy have no effect.

Optional Feature:
- Macro: RISC5_MULDIV_FAST_MUL_EN.
- Defined:
  - MUL, MULH, MULHSU and MULHU use a single-cycle 2*XLEN combinational multiplier.
  - Operands are captured at edge k; the multiply goes IDLE→FIN, so done appears in cycle k+2.
  - Divide ops are unchanged.
- Undefined:
  - All multiplies use the iterative CALC path, with XLEN+2 cycles latency.
  - No multiplier cell is inferred.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1 → busy=0, done=0, result=0 throughout; release reset → IDLE, no spurious done.
- MULH signed: XLEN=32, op_a=0xFFFFFFFE (-2), op_b=0x00000003, funct3=001 → done in cycle k+34, result=0xFFFFFFFF. Same operands with MUL (000) → result=0xFFFFFFFA.
- DIV/REM signed: op_a=0xFFFFFFF9 (-7), op_b=2. DIV → result=0xFFFFFFFD (-3); REM → result=0xFFFFFFFF (-1). REMU with the same operands → result=0x00000001.
- Specials:
  - DIVU by 0 with op_a=0x12345678 → result=0xFFFFFFFF in cycle k+2.
  - REM by 0 → result=0x12345678.
  - DIV 0x80000000 / 0xFFFFFFFF → result=0x80000000; REM with the same operands → result=0.
- Flush/abort: start DIVU 100/7, assert flush at cycle k+10 → busy=0 at k+11, no done pulse, result unchanged. An immediate new start of DIVU 100/7 → result=14.
- Handshake: pulse start again at k+5 while busy with different operands → first op completes with its original result, the second start is ignored. With RISC5_MULDIV_FAST_MUL_EN defined, MUL 6*7 → result=42 in cycle k+2.

Source files
------------

// File: rtl/risc5_muldiv_unit.sv
// ============================================================================
// Module      : risc5_muldiv_unit
// Description : Iterative RV32M/RV64M multiply/divide unit beside the EX ALU.
//               Define RISC5_MULDIV_FAST_MUL_EN for a single-cycle multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module risc5_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0]      c_idle    = 2'd0;
    localparam logic [1:0]      c_calc    = 2'd1;
    localparam logic [1:0]      c_fin     = 2'd2;
    localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_acc;   // product high half / partial remainder
    logic [XLEN-1:0] r_lo;    // product low half / dividend -> quotient
    logic [XLEN-1:0] r_b;     // multiplicand / divisor magnitude
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    logic            w_accept;
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_zero;
    logic            w_ovf;
    logic [XLEN:0]   w_madd;
    logic [XLEN:0]   w_shift;
    logic            w_ge;
    logic [XLEN-1:0] w_sub;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic [XLEN-1:0] w_sel;

    assign w_accept   = (r_state == c_idle) && start && !flush && !r_done;
    assign w_is_div   = funct3[2];
    assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_a_neg    = w_a_signed && op_a[XLEN-1];
    assign w_b_neg    = w_b_signed && op_b[XLEN-1];
    assign w_a_mag    = w_a_neg ? -op_a : op_a;
    assign w_b_mag    = w_b_neg ? -op_b : op_b;
    assign w_div_zero = (op_b == '0);
    assign w_ovf      = w_b_signed && (op_a == c_int_min) && (op_b == '1);

    // Shift-add step: conditionally add multiplicand, shift {acc,lo} right.
    assign w_madd  = {1'b0, r_acc} + {1'b0, (r_lo[0] ? r_b : {XLEN{1'b0}})};
    // Restoring step: the true difference always fits XLEN bits when w_ge.
    assign w_shift = {r_acc, r_lo[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, r_b});
    assign w_sub   = w_shift[XLEN-1:0] - r_b;

    assign w_prod     = {r_acc, r_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_q ? -r_lo : r_lo;
    assign w_rem_fix  = r_neg_r ? -r_acc : r_acc;

`ifdef RISC5_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast;
    assign w_fast = {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};
`endif

    always_comb begin
        w_sel = r_result;
        case (r_funct3)
            3'b000:                 w_sel = w_prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_sel = w_prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_sel = w_quo_fix;
            default:                w_sel = w_rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= c_idle;
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_funct3 <= funct3;
                        r_cnt    <= CNT_W'(XLEN);
                        r_busy   <= 1'b1;
                        r_b      <= w_b_mag;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_acc    <= '0;
                        r_lo     <= w_a_mag;
                        r_state  <= c_calc;
                        // Special divides preload raw quotient/remainder, no sign fix.
                        if (w_is_div && w_div_zero) begin
                            r_lo    <= '1;
                            r_acc   <= op_a;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= c_fin;
                        end else if (w_is_div && w_ovf) begin
                            r_lo    <= op_a;
                            r_acc   <= '0;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= c_fin;
                        end
`ifdef RISC5_MULDIV_FAST_MUL_EN
                        else if (!w_is_div) begin
                            r_acc   <= w_fast[2*XLEN-1:XLEN];
                            r_lo    <= w_fast[XLEN-1:0];
                            r_state <= c_fin;
                        end
`endif
                    end
                end
                c_calc: begin
                    if (flush) begin
                        r_state <= c_idle;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_funct3[2]) begin
                            r_acc <= w_ge ? w_sub : w_shift[XLEN-1:0];
                            r_lo  <= {r_lo[XLEN-2:0], w_ge};
                        end else begin
                            r_acc <= w_madd[XLEN:1];
                            r_lo  <= {w_madd[0], r_lo[XLEN-1:1]};
                        end
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= c_fin;
                        end
                    end
                end
                c_fin: begin
                    r_state <= c_idle;
                    r_busy  <= 1'b0;
                    if (!flush) begin
                        r_result <= w_sel;
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_risc5_muldiv_unit.sv
// ============================================================================
// Module      : tb_risc5_muldiv_unit
// Description : Self-checking bench: transaction-level model plus directed and
//               randomized stimulus for risc5_muldiv_unit (XLEN=32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_risc5_muldiv_unit;

    localparam int XLEN = 32;
`ifdef RISC5_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = XLEN + 2;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int   n_vec   = 0;
    int   n_err   = 0;
    int   cyc     = 0;
    bit   started = 1'b0;

    bit          m_busy   = 1'b0;
    bit          m_done   = 1'b0;
    int          m_left   = 0;
    logic [31:0] m_pend   = '0;
    logic [31:0] m_result = '0;

    always #5 clk = ~clk;

    risc5_muldiv_unit #(.XLEN(XLEN)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Architectural result of an RV32M op computed with 64-bit arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            3'b000: begin p = ua * ub;          return p[31:0];  end
            3'b001: begin p = sa * sb;          return p[63:32]; end
            3'b010: begin p = sa * $signed(ub); return p[63:32]; end
            3'b011: begin p = ua * ub;          return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Cycles from the accepting edge to the done cycle.
    function automatic int op_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2]) begin
            if (b == 0) return 2;
            if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
            return XLEN + 2;
        end
        return MUL_LAT;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction model: one pending op with a countdown to its done cycle.
    always @(posedge clk) begin
        bit was_done;
        cyc++;
        started  = 1'b1;
        was_done = m_done;
        m_done   = 1'b0;
        if (!reset) begin
            m_busy   = 1'b0;
            m_result = '0;
        end else if (m_busy) begin
            if (flush) begin
                m_busy = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy   = 1'b0;
                    m_done   = 1'b1;
                    m_result = m_pend;
                end
            end
        end else if (start && !flush && !was_done) begin
            m_busy = 1'b1;
            m_pend = ref_op(funct3, op_a, op_b);
            m_left = op_lat(funct3, op_a, op_b) - 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("result", result, m_result);
        end
    end

    task automatic wait_done(input int k, input int lat, input logic [31:0] exp, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < XLEN + 10 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                chk({nm, " latency"}, 32'(cyc - k + 1), 32'(lat));
                chk(nm, result, exp);
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: got no done, expected done within %0d cycles", nm, lat);
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string nm);
        int k;
        @(posedge clk); #2;
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        @(posedge clk); #1;
        k = cyc;
        start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
        wait_done(k, lat, exp, nm);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k;
        reset = 1'b0; start = 1'b1; flush = 1'b0; funct3 = 3'b000; op_a = 32'd5; op_b = 32'd6;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("reset result", result, 32'h0);
        chk("reset done", 32'(done), 32'h0);

        run_op(3'b001, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, XLEN + 2, "MULH -2*3");
        run_op(3'b000, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFA, MUL_LAT, "MUL -2*3");
        run_op(3'b100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, XLEN + 2, "DIV -7/2");
        run_op(3'b110, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, XLEN + 2, "REM -7/2");
        run_op(3'b111, 32'hFFFF_FFF9, 32'h2, 32'h0000_0001, XLEN + 2, "REMU");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "DIV ovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2, "REM ovf");
        run_op(3'b110, 32'h1234_5678, 32'h0, 32'h1234_5678, 2, "REM by 0");
        run_op(3'b101, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 2, "DIVU by 0");

        // Abort a DIVU mid-flight; result must keep the divide-by-zero value.
        @(posedge clk); #2;
        start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk); #1;
        k = cyc;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 flush = 1'b1;
        @(posedge clk); #2 flush = 1'b0;
        @(negedge clk);
        chk("flush busy", 32'(busy), 32'h0);
        chk("flush done", 32'(done), 32'h0);
        chk("flush result", result, 32'hFFFF_FFFF);
        run_op(3'b101, 32'd100, 32'd7, 32'd14, XLEN + 2, "DIVU after flush");

        // Second start while busy must be ignored.
        @(posedge clk); #2;
        start = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3;
        @(posedge clk); #1;
        k = cyc;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 start = 1'b1; funct3 = 3'b000; op_a = 32'd5; op_b = 32'd5;
        @(posedge clk); #2 start = 1'b0;
        wait_done(k, XLEN + 2, 32'd333, "start while busy");

        run_op(3'b000, 32'd6, 32'd7, 32'd42, MUL_LAT, "MUL 6*7");
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "MULHU max");
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, "MULHSU -1");

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            reset  = ($urandom_range(0, 499) != 0);
            start  = ($urandom_range(0, 3) == 0);
            flush  = ($urandom_range(0, 99) == 0);
            funct3 = 3'($urandom);
            op_a   = pick();
            op_b   = pick();
        end
        @(posedge clk); #2;
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        repeat (XLEN + 4) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
